bpsk_carrier_mod: RTL and testbench

//  Transmit-side counterpart of the carrier-recovery loop: BPSK-modulates a bit stream onto an NCO carrier.

---
 rtl/bpsk_mod_pkg.sv | 31 +++
 rtl/nco_sin_lut.sv | 41 ++++
 rtl/bpsk_carrier_mod.sv | 159 +++++++++++++++
 tb/tb_bpsk_carrier_mod.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpsk_mod_pkg.sv
// Shared types, constants and Q1.15 helpers for the BPSK carrier modulator.
package bpsk_mod_pkg;

  typedef struct packed {
    logic signed [15:0] i;
    logic signed [15:0] q;
  } iq_sample_t;

  typedef struct packed {
    logic        sym;
    logic        last;
    logic [15:0] gain;
  } sym_entry_t;

  localparam logic signed [15:0] Q15_MAX = 16'sd32767;

  // Quarter of a full turn expressed on a 32-bit phase scale; narrower phase
  // words take the top bits.
  localparam logic [31:0] QUARTER_TURN = 32'h4000_0000;

  // Symmetric saturation keeps -32768 out so a later negation cannot overflow.
  function automatic logic signed [15:0] saturate_q15(input logic signed [32:0] v);
    if (v > 33'sd32767)
      return Q15_MAX;
    else if (v < -33'sd32767)
      return -Q15_MAX;
    else
      return v[15:0];
  endfunction

endpackage

// File: rtl/nco_sin_lut.sv
// Registered sine/cosine lookup; cosine reads the sine ROM a quarter turn ahead.
module nco_sin_lut
  import bpsk_mod_pkg::*;
#(
  parameter int unsigned LUT_AW = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [LUT_AW-1:0]        addr,
  output logic signed [15:0]       sin_q,
  output logic signed [15:0]       cos_q
);

  localparam int unsigned         DEPTH  = 1 << LUT_AW;
  localparam logic [LUT_AW-1:0]   QTR    = LUT_AW'(QUARTER_TURN >> (32 - LUT_AW));
  localparam real                 TWO_PI = 6.283185307179586;

  logic signed [15:0] rom [DEPTH];
  logic [LUT_AW-1:0]  cos_addr;

  // Table contents are fixed at elaboration, rounded to nearest Q1.15.
  for (genvar a = 0; a < DEPTH; a++) begin : g_rom
    localparam real X = 32767.0 * $sin(TWO_PI * a / DEPTH);
    localparam int  V = (X >= 0.0) ? $rtoi(X + 0.5) : -$rtoi(0.5 - X);
    assign rom[a] = 16'(V);
  end

  assign cos_addr = addr + QTR;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sin_q <= '0;
      cos_q <= '0;
    end else if (en) begin
      sin_q <= rom[addr];
      cos_q <= rom[cos_addr];
    end
  end

endmodule

// File: rtl/bpsk_carrier_mod.sv
// BPSK modulator: one input bit per symbol, SPS NCO-carrier IQ samples out.
// Optional macro DIFF_ENC_EN enables differential encoding of the symbols.
module bpsk_carrier_mod
  import bpsk_mod_pkg::*;
#(
  parameter int unsigned        C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned        C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned        SPS                    = 16,
  parameter int unsigned        PHASE_W                = 24,
  parameter int unsigned        LUT_AW                 = 10,
  parameter logic [PHASE_W-1:0] PHASE_INC              = 24'h040000
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_areset,
  input  logic                                  s00_axis_tvalid,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic                                  s00_axis_tlast,
  output logic                                  s00_axis_tready,
  input  logic [15:0]                           gain,
  input  logic                                  m00_axis_tready,
  output logic                                  m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic                                  m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb
);

  localparam int unsigned KW = (SPS > 2) ? $clog2(SPS) : 1;

  logic               clk, rst;
  logic               advance, issue, retire, accept;
  logic               sym_in;
  logic               tdata_unused;
  sym_entry_t         entry;
  logic               full;
  logic [KW-1:0]      k;
  logic [PHASE_W-1:0] phase;

  logic               s0_v, s0_sym, s0_last;
  logic [15:0]        s0_gain;
  logic [LUT_AW-1:0]  s0_addr;
  logic               s1_v, s1_sym, s1_last;
  logic [15:0]        s1_gain;
  logic signed [15:0] sin_q, cos_q;
  logic signed [32:0] prod_i, prod_q;
  iq_sample_t         iq_sat, iq_out;

  assign clk          = s00_axis_aclk;
  assign rst          = s00_axis_areset;
  assign tdata_unused = ^s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:1];

  assign advance = !m00_axis_tvalid || m00_axis_tready;
  assign issue   = full && advance;
  assign retire  = issue && (k == KW'(SPS - 1));
  // A retiring entry frees the register in the same cycle, so symbols chain gaplessly.
  assign s00_axis_tready = !rst && (!full || retire);
  assign accept  = s00_axis_tvalid && s00_axis_tready;

`ifdef DIFF_ENC_EN
  logic d_prev, d_base;
  // A packet boundary retiring this cycle must already see the cleared reference.
  assign d_base = (retire && entry.last) ? 1'b0 : d_prev;
  assign sym_in = s00_axis_tdata[0] ^ d_base;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      d_prev <= 1'b0;
    else if (accept)
      d_prev <= sym_in;
    else if (retire && entry.last)
      d_prev <= 1'b0;
  end
`else
  assign sym_in = s00_axis_tdata[0];
`endif

  // Symbol register and issue stage; phase and k only move while a sample issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry <= '0;
      full  <= 1'b0;
      k     <= '0;
      phase <= '0;
    end else begin
      if (accept) begin
        entry <= '{sym: sym_in, last: s00_axis_tlast, gain: gain};
        full  <= 1'b1;
      end else if (retire) begin
        full  <= 1'b0;
      end
      if (issue) begin
        phase <= phase + PHASE_INC;
        k     <= retire ? '0 : k + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_v    <= 1'b0;
      s0_sym  <= 1'b0;
      s0_last <= 1'b0;
      s0_gain <= '0;
      s0_addr <= '0;
    end else if (advance) begin
      s0_v    <= issue;
      s0_sym  <= entry.sym;
      s0_last <= entry.last && (k == KW'(SPS - 1));
      s0_gain <= entry.gain;
      s0_addr <= phase[PHASE_W-1 -: LUT_AW];
    end
  end

  nco_sin_lut #(
    .LUT_AW (LUT_AW)
  ) u_lut (
    .clk   (clk),
    .rst   (rst),
    .en    (advance),
    .addr  (s0_addr),
    .sin_q (sin_q),
    .cos_q (cos_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_sym  <= 1'b0;
      s1_last <= 1'b0;
      s1_gain <= '0;
    end else if (advance) begin
      s1_v    <= s0_v;
      s1_sym  <= s0_sym;
      s1_last <= s0_last;
      s1_gain <= s0_gain;
    end
  end

  assign prod_i   = 33'(cos_q) * 33'($signed({1'b0, s1_gain}));
  assign prod_q   = 33'(sin_q) * 33'($signed({1'b0, s1_gain}));
  assign iq_sat.i = saturate_q15(prod_i >>> 15);
  assign iq_sat.q = saturate_q15(prod_q >>> 15);
  assign iq_out.i = s1_sym ? iq_sat.i : -iq_sat.i;
  assign iq_out.q = s1_sym ? iq_sat.q : -iq_sat.q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m00_axis_tvalid <= 1'b0;
      m00_axis_tdata  <= '0;
      m00_axis_tlast  <= 1'b0;
      m00_axis_tstrb  <= '0;
    end else if (advance) begin
      m00_axis_tvalid <= s1_v;
      m00_axis_tdata  <= s1_v ? C_M00_AXIS_TDATA_WIDTH'(iq_out) : '0;
      m00_axis_tlast  <= s1_v && s1_last;
      m00_axis_tstrb  <= s1_v ? '1 : '0;
    end
  end

endmodule

// File: tb/tb_bpsk_carrier_mod.sv
// Randomized self-checking bench for bpsk_carrier_mod (carrier at fs/4).
`timescale 1ns/1ps
module tb_bpsk_carrier_mod;

  localparam int unsigned SPS = 16;
  localparam logic [23:0] INC = 24'h400000;
  localparam real         TWO_PI = 6.283185307179586;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_tvalid = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [15:0] gain = '0;
  logic        m_tready = 1'b1;
  logic        m_tvalid;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic [3:0]  m_tstrb;

  always #5 clk = ~clk;

  bpsk_carrier_mod #(
    .SPS       (SPS),
    .PHASE_INC (INC)
  ) dut (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .s00_axis_tvalid (s_tvalid),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tlast  (s_tlast),
    .s00_axis_tready (s_tready),
    .gain            (gain),
    .m00_axis_tready (m_tready),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tlast  (m_tlast),
    .m00_axis_tstrb  (m_tstrb)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference model: sample n of the stream sits at carrier phase n*INC.
  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] obs[$];
  int unsigned n_model = 0;
  logic        d_prev_m = 1'b0;
  int unsigned rdy_mode = 0;

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else          return -$rtoi(0.5 - x);
  endfunction

  function automatic int amp(input int v, input logic [15:0] g);
    longint p;
    p = longint'(v) * longint'(g);
    p = p >>> 15;
    if (p > 32767)  p = 32767;
    if (p < -32767) p = -32767;
    return int'(p);
  endfunction

  function automatic logic [31:0] pack_iq(input int i, input int q);
    logic [31:0] r;
    r = {i[15:0], q[15:0]};
    return r;
  endfunction

  task automatic model_push(input logic b, input logic last, input logic [15:0] g);
    logic        s;
    logic [23:0] ph;
    int          addr, ci, si, vi, vq;
    real         ang;
    exp_t        e;
    s = b;
`ifdef DIFF_ENC_EN
    s = b ^ d_prev_m;
    d_prev_m = last ? 1'b0 : s;
`endif
    for (int unsigned j = 0; j < SPS; j++) begin
      ph   = 24'(n_model * INC);
      addr = int'(ph >> 14);
      ang  = TWO_PI * addr / 1024.0;
      ci   = rnd(32767.0 * $cos(ang));
      si   = rnd(32767.0 * $sin(ang));
      vi   = amp(ci, g);
      vq   = amp(si, g);
      if (!s) begin
        vi = -vi;
        vq = -vq;
      end
      e.data = pack_iq(vi, vq);
      e.last = last && (j == SPS - 1);
      expq.push_back(e);
      n_model++;
    end
  endtask

  task automatic send_sym(input logic b, input logic last, input logic [15:0] g, input int unsigned gap);
    repeat (gap) @(posedge clk);
    if (gap != 0) #1;
    s_tvalid = 1'b1;
    s_tdata  = {$urandom, 1'b0} | 32'(b);
    s_tlast  = last;
    gain     = g;
    for (int unsigned t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (s_tready) begin
        model_push(b, last, g);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        gain     = 16'($urandom);
        return;
      end
    end
    check("accept_timeout", 0, 1);
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    int unsigned t;
    t = 0;
    while ((expq.size() != 0 || m_tvalid) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("drain_queue_empty", expq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_m_tvalid"}, m_tvalid, 0);
    check({pfx, "_m_tdata"},  m_tdata,  0);
    check({pfx, "_m_tlast"},  m_tlast,  0);
    check({pfx, "_m_tstrb"},  m_tstrb,  0);
    check({pfx, "_s_tready"}, s_tready, 0);
  endtask

  task automatic model_reset();
    expq.delete();
    obs.delete();
    n_model  = 0;
    d_prev_m = 1'b0;
  endtask

  // Sink-ready driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_tready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Output monitor: scoreboard compare plus hold-while-stalled check.
  initial begin
    logic [31:0] held_d;
    logic        held_l;
    logic        held_v;
    exp_t        e;
    held_v = 1'b0;
    held_d = '0;
    held_l = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          check("stall_tvalid", m_tvalid, 1);
          check("stall_tdata",  m_tdata,  held_d);
          check("stall_tlast",  m_tlast,  held_l);
        end
        if (m_tvalid && m_tready) begin
          if (expq.size() == 0) begin
            check("unexpected_sample", 1, 0);
          end else begin
            e = expq.pop_front();
            check("sample_data", m_tdata, e.data);
            check("sample_last", m_tlast, e.last);
            check("sample_strb", m_tstrb, 4'hF);
          end
          obs.push_back(m_tdata);
        end
        held_v = m_tvalid && !m_tready;
        held_d = m_tdata;
        held_l = m_tlast;
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] tbl[4];
  logic        b4[4];
  logic [15:0] g4[4];
  logic [31:0] burst_obs[$];
  int          exp6[4];
  int unsigned lat, run, nlast, base;

  initial begin
    tbl[0] = pack_iq(32767, 0);
    tbl[1] = pack_iq(0, 32767);
    tbl[2] = pack_iq(-32767, 0);
    tbl[3] = pack_iq(0, -32767);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single sym=1 at unity gain: latency and quadrature cycle
    send_sym(1'b1, 1'b1, 16'h8000, 0);
    lat = 0;
    for (int unsigned i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (m_tvalid) begin
        lat = i;
        break;
      end
    end
    check("latency", lat, 3);
    drain();
    for (int unsigned j = 0; j < SPS; j++)
      check("sym1_iq", obs[j], tbl[j % 4]);

    // sym=0: exact negation, never full-scale negative
    base = obs.size();
    send_sym(1'b0, 1'b1, 16'h8000, 2);
    drain();
    for (int unsigned j = 0; j < SPS; j++) begin
      check("sym0_iq", obs[base + j], pack_iq(-$signed(tbl[j % 4][31:16]), -$signed(tbl[j % 4][15:0])));
      check("sym0_no_min_i", obs[base + j][31:16], obs[base + j][31:16] == 16'h8000 ? 16'h7FFF : obs[base + j][31:16]);
    end

    // 4 back-to-back symbols, sink always ready
    for (int i = 0; i < 4; i++) begin
      b4[i] = 1'($urandom);
      g4[i] = 16'($urandom);
    end
    base = obs.size();
    run = 0;
    nlast = 0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send_sym(b4[i], i == 3, g4[i], 0);
      end
      begin
        for (int unsigned t = 0; t < 50 && !m_tvalid; t++)
          @(negedge clk);
        while (m_tvalid && run < 200) begin
          run++;
          if (m_tlast) nlast++;
          @(negedge clk);
        end
      end
    join
    drain();
    check("burst_len", run, 64);
    check("burst_tlast_count", nlast, 1);
    for (int unsigned j = 0; j < 64; j++)
      burst_obs.push_back(obs[base + j]);

    // Same burst under random backpressure, then random traffic
    rdy_mode = 1;
    base = obs.size();
    for (int i = 0; i < 4; i++)
      send_sym(b4[i], i == 3, g4[i], 0);
    drain();
    for (int unsigned j = 0; j < 64; j++)
      check("stalled_burst_match", obs[base + j], burst_obs[j]);
    for (int i = 0; i < 30; i++)
      send_sym(1'($urandom), $urandom_range(0, 3) == 0, 16'($urandom), $urandom_range(0, 3));
    send_sym(1'($urandom), 1'b1, 16'($urandom), 0);
    drain();
    rdy_mode = 0;

    // Fresh reset, then 1,1,0,1 at half gain
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    send_sym(1'b1, 1'b0, 16'h4000, 1);
    send_sym(1'b1, 1'b0, 16'h4000, 0);
    send_sym(1'b0, 1'b0, 16'h4000, 0);
    send_sym(1'b1, 1'b1, 16'h4000, 0);
    drain();
`ifdef DIFF_ENC_EN
    exp6[0] = 16383; exp6[1] = -16383; exp6[2] = -16383; exp6[3] = 16383;
`else
    exp6[0] = 16383; exp6[1] = 16383;  exp6[2] = -16383; exp6[3] = 16383;
`endif
    for (int unsigned s = 0; s < 4; s++)
      check("half_gain_first_i", longint'($signed(obs[s * SPS][31:16])), exp6[s]);

    // Asynchronous reset during sample 5 of a symbol
    base = obs.size();
    send_sym(1'b1, 1'b0, 16'h8000, 0);
    for (int unsigned t = 0; t < 100 && obs.size() < base + 5; t++)
      @(posedge clk);
    check("reset_mid_burst_reached", obs.size(), base + 5);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_outputs_zero("async_reset");
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    send_sym(1'b0, 1'b1, 16'h8000, 2);
    drain();
    check("post_reset_first_sample", obs[0], pack_iq(-32767, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
